// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

  localparam logic        GNT_IF       = 1'b0;
  localparam logic        GNT_DM       = 1'b1;
  localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;
  localparam int unsigned ARB_CNT_W    = 8;

endpackage

// File: rtl/arb_timer.sv
// Wait counter for an outstanding memory transaction; expired flags the
// cycle whose increment would reach the limit.
module arb_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign expired = en & (r_cnt == (limit - W'(1)));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data-memory requests onto one shared memory port.
// Define MEM_ARB_RR_EN for round-robin arbitration (default: dm over if).
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              err
);

  arb_state_t        r_state, w_state_nxt;
  logic              r_mem_req, w_mem_req_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic              r_if_ready, w_if_ready_nxt;
  logic [DATA_W-1:0] r_if_rdata, w_if_rdata_nxt;
  logic              r_dm_ready, w_dm_ready_nxt;
  logic [DATA_W-1:0] r_dm_rdata, w_dm_rdata_nxt;
  logic              r_err, w_err_nxt;

  logic              w_gnt;
  logic              w_gnt_valid;
  logic              w_timer_clr;
  logic              w_timer_en;
  logic              w_expired;

  // No grant during a ready pulse: the finished requester may still hold req.
  assign w_gnt_valid = (if_req | dm_req) & ~r_if_ready & ~r_dm_ready;

`ifdef MEM_ARB_RR_EN
  logic r_last_gnt;

  always_comb begin
    w_gnt = dm_req ? GNT_DM : GNT_IF;
    if (if_req && dm_req) begin
      w_gnt = (r_last_gnt == GNT_DM) ? GNT_IF : GNT_DM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_gnt <= GNT_IF;
    end else if ((r_state == IDLE) && w_gnt_valid) begin
      r_last_gnt <= w_gnt;
    end
  end
`else
  assign w_gnt = dm_req ? GNT_DM : GNT_IF;
`endif

  arb_timer #(.W(ARB_CNT_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_timer_clr),
    .en      (w_timer_en),
    .limit   (ARB_CNT_W'(TIMEOUT_CYC)),
    .expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ready  <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_ready  <= 1'b0;
      r_dm_rdata  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_if_ready  <= w_if_ready_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_dm_ready  <= w_dm_ready_nxt;
      r_dm_rdata  <= w_dm_rdata_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // Next-state and next-output logic; mem_ack wins over a same-cycle timeout.
  always_comb begin
    w_state_nxt     = r_state;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_if_ready_nxt  = 1'b0;
    w_if_rdata_nxt  = r_if_rdata;
    w_dm_ready_nxt  = 1'b0;
    w_dm_rdata_nxt  = r_dm_rdata;
    w_err_nxt       = r_err;
    w_timer_clr     = 1'b0;
    w_timer_en      = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_mem_req_nxt = 1'b1;
          w_timer_clr   = 1'b1;
          if (w_gnt == GNT_DM) begin
            w_state_nxt     = BUSY_DM;
            w_mem_we_nxt    = dm_we;
            w_mem_addr_nxt  = dm_addr;
            w_mem_wdata_nxt = dm_wdata;
          end else begin
            w_state_nxt     = BUSY_IF;
            w_mem_we_nxt    = 1'b0;
            w_mem_addr_nxt  = if_addr;
            w_mem_wdata_nxt = '0;
          end
        end
      end
      BUSY_IF, BUSY_DM: begin
        w_timer_en = ~mem_ack;
        if (mem_ack || w_expired) begin
          w_state_nxt   = IDLE;
          w_mem_req_nxt = 1'b0;
          w_mem_we_nxt  = 1'b0;
          if (r_state == BUSY_IF) begin
            w_if_ready_nxt = 1'b1;
            w_if_rdata_nxt = mem_ack ? mem_rdata : DATA_W'(ARB_ERR_DATA);
          end else begin
            w_dm_ready_nxt = 1'b1;
            if (!mem_ack) begin
              w_dm_rdata_nxt = DATA_W'(ARB_ERR_DATA);
            end else if (!r_mem_we) begin
              w_dm_rdata_nxt = mem_rdata;
            end
          end
          if (!mem_ack) begin
            w_err_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_ready  = r_if_ready;
  assign if_rdata  = r_if_rdata;
  assign dm_ready  = r_dm_ready;
  assign dm_rdata  = r_dm_rdata;
  assign err       = r_err;
  assign stall     = ~rst & ((if_req & ~r_if_ready) | (dm_req & ~r_dm_ready));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT_CYC = 4).
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ready  (dm_ready),
    .dm_rdata  (dm_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .stall     (stall),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Step negedges until mem_req is seen (bounded).
  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (mem_req !== 1'b1) check({tag, "_req_timeout"}, 64'(mem_req), 64'd1);
  endtask

  // Called in busy cycle 1; asserts ack in busy cycle lat, returns in the ready cycle.
  task automatic ack_after(input int lat, input logic [31:0] d);
    repeat (lat - 1) @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = d;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] seq_addr[4];
    logic [31:0] exp_addr[4];

    rst = 1'b1; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0;
    dm_addr = '0; dm_wdata = '0; mem_ack = 0; mem_rdata = '0;
    @(negedge clk); @(negedge clk);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_ready", 64'({if_ready, dm_ready}), 64'd0);
    check("rst_data", 64'(mem_addr | mem_wdata | if_rdata | dm_rdata), 64'd0);
    check("rst_err_stall", 64'({err, stall, mem_we}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single fetch, ack in 3rd busy cycle
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    check("f1_mem_req", 64'(mem_req), 64'd1);
    check("f1_mem_addr", 64'(mem_addr), 64'h40);
    check("f1_stall_busy", 64'(stall), 64'd1);
    ack_after(3, 32'h2008_0005);
    check("f1_if_ready", 64'(if_ready), 64'd1);
    check("f1_if_rdata", 64'(if_rdata), 64'h2008_0005);
    check("f1_stall_fall", 64'(stall), 64'd0);
    check("f1_req_drop", 64'(mem_req), 64'd0);
    if_req = 1'b0;
    @(negedge clk);
    check("f1_ready_once", 64'(if_ready), 64'd0);

    // Collision: dm first, then if
    if_req = 1'b1; if_addr = 32'h44; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    @(negedge clk);
    check("col_dm_first", 64'(mem_addr), 64'h200);
    ack_after(1, 32'h1111_2222);
    check("col_dm_ready", 64'({dm_ready, if_ready}), 64'b10);
    check("col_dm_rdata", 64'(dm_rdata), 64'h1111_2222);
    check("col_stall_if", 64'(stall), 64'd1);
    dm_req = 1'b0;
    @(negedge clk);
    check("col_dm_once", 64'({dm_ready, mem_req}), 64'd0);
    wait_req("col_if");
    check("col_if_addr", 64'(mem_addr), 64'h44);
    ack_after(1, 32'h3333_4444);
    check("col_if_ready", 64'({dm_ready, if_ready}), 64'b01);
    check("col_if_rdata", 64'(if_rdata), 64'h3333_4444);
    if_req = 1'b0;
    @(negedge clk);
    check("col_if_once", 64'(if_ready), 64'd0);

    // Store: held address/data, dm_rdata unchanged
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hCAFE;
    wait_req("st");
    check("st_bus", 64'({mem_we, mem_addr, mem_wdata[30:0]}), {1'b1, 32'h100, 31'hCAFE});
    dm_wdata = 32'h0; dm_addr = 32'h0;
    @(negedge clk); @(negedge clk);
    check("st_hold", 64'({mem_req, mem_we, mem_addr, mem_wdata[29:0]}), {2'b11, 32'h100, 30'hCAFE});
    mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    check("st_ready", 64'(dm_ready), 64'd1);
    check("st_rdata_kept", 64'(dm_rdata), 64'h1111_2222);
    dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk);

    // mem_ack in IDLE ignored
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    check("idle_ack", 64'({mem_req, if_ready, dm_ready}), 64'd0);

    // Timeout after 4 busy cycles
    if_req = 1'b1; if_addr = 32'h80;
    wait_req("to");
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("to_busy4", 64'({mem_req, if_ready, err}), 64'b100);
    @(negedge clk);
    check("to_drop", 64'({mem_req, if_ready, err}), 64'b011);
    check("to_rdata", 64'(if_rdata), 64'hDEAD_BEEF);
    if_req = 1'b0;
    @(negedge clk);
    check("to_err_sticky", 64'({err, if_ready}), 64'b10);

    // Normal fetch afterwards, err stays set
    if_req = 1'b1; if_addr = 32'h84;
    wait_req("f2");
    ack_after(2, 32'h0BAD_F00D);
    check("f2_ready", 64'({if_ready, err}), 64'b11);
    check("f2_rdata", 64'(if_rdata), 64'h0BAD_F00D);
    if_req = 1'b0;
    @(negedge clk);

    // Reset two cycles after grant
    if_req = 1'b1; if_addr = 32'hC0;
    wait_req("rb");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rb_outs", 64'({mem_req, mem_we, if_ready, dm_ready, err}), 64'd0);
    check("rb_data", 64'(mem_addr | mem_wdata | if_rdata | dm_rdata), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    check("rb_no_ready", 64'(if_ready), 64'd0);
    wait_req("rb2");
    check("rb2_addr", 64'(mem_addr), 64'hC0);
    ack_after(2, 32'h5555_AAAA);
    check("rb2_ready", 64'({if_ready, err}), 64'b10);
    check("rb2_rdata", 64'(if_rdata), 64'h5555_AAAA);
    if_req = 1'b0;
    @(negedge clk);

    // Both held high: grant order
    if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
`ifdef MEM_ARB_RR_EN
    exp_addr[0] = 32'h20; exp_addr[1] = 32'h10; exp_addr[2] = 32'h20; exp_addr[3] = 32'h10;
`else
    exp_addr[0] = 32'h20; exp_addr[1] = 32'h20; exp_addr[2] = 32'h20; exp_addr[3] = 32'h20;
`endif
    for (int i = 0; i < 4; i++) begin
      wait_req("ord");
      seq_addr[i] = mem_addr;
      check($sformatf("ord_gnt%0d", i), 64'(seq_addr[i]), 64'(exp_addr[i]));
      ack_after(1, 32'h0000_1000 + 32'(i));
    end
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk); @(negedge clk);
    check("ord_idle", 64'({mem_req, stall}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
